// File: rtl/ysyx_axi_arbiter.sv
// ysyx_axi_arbiter: shares one 64-bit AXI4 master port between IFU fetches and LSU loads/stores
module ysyx_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready_o,
  output logic              err_o,
  input  logic              io_master_awready,
  output logic              io_master_awvalid,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [3:0]        io_master_awid,
  output logic [7:0]        io_master_awlen,
  output logic [2:0]        io_master_awsize,
  output logic [1:0]        io_master_awburst,
  input  logic              io_master_wready,
  output logic              io_master_wvalid,
  output logic [63:0]       io_master_wdata,
  output logic [7:0]        io_master_wstrb,
  output logic              io_master_wlast,
  output logic              io_master_bready,
  input  logic              io_master_bvalid,
  input  logic [1:0]        io_master_bresp,
  input  logic              io_master_arready,
  output logic              io_master_arvalid,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [3:0]        io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  output logic              io_master_rready,
  input  logic              io_master_rvalid,
  input  logic [1:0]        io_master_rresp,
  input  logic [63:0]       io_master_rdata,
  input  logic              io_master_rlast
);
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_e;
  state_e state_q, state_d;
  logic last_lsu_q, last_lsu_d, own_lsu_q, own_lsu_d, wr_q, wr_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d, rword, wsh;
  logic pick_lsu;
  function automatic logic [2:0] size_of(input logic [7:0] s);
    return s == 8'h01 ? 3'd0 : s == 8'h03 ? 3'd1 : 3'd2;
  endfunction
  assign pick_lsu = lsu_arvalid && (!ifu_arvalid || !last_lsu_q);
  assign rword = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  assign wsh = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
  // Grant selection, AXI channel sequencing and response capture
  always_comb begin
    state_d = state_q;
    last_lsu_d = last_lsu_q;
    own_lsu_d = own_lsu_q;
    wr_d = wr_q;
    addr_d = addr_q;
    size_d = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    resp_d = resp_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        if (lsu_wvalid) begin
          own_lsu_d = 1'b1;
          wr_d = 1'b1;
          addr_d = lsu_awaddr;
          size_d = size_of(lsu_wstrb);
          wdata_d = {wsh, wsh};
          wstrb_d = lsu_wstrb << lsu_awaddr[2:0];
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
          state_d = AW_W;
        end else if (lsu_arvalid || ifu_arvalid) begin
          own_lsu_d = pick_lsu;
          wr_d = 1'b0;
          addr_d = pick_lsu ? lsu_araddr : ifu_araddr;
          size_d = pick_lsu ? size_of(lsu_rstrb) : 3'd2;
          last_lsu_d = (lsu_arvalid && ifu_arvalid) ? pick_lsu : last_lsu_q;
          state_d = AR;
        end
      end
      AR: state_d = io_master_arready ? R : AR;
      R: begin
        if (io_master_rvalid && io_master_rlast) begin
          data_d = rword >> {addr_q[1:0], 3'b000};
          resp_d = io_master_rresp;
          state_d = DONE;
        end
      end
      AW_W: begin
        aw_done_d = aw_done_q | (io_master_awvalid & io_master_awready);
        w_done_d = w_done_q | (io_master_wvalid & io_master_wready);
        state_d = (aw_done_d && w_done_d) ? B : AW_W;
      end
      B: begin
        if (io_master_bvalid) begin
          resp_d = io_master_bresp;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_lsu_q <= 1'b0;
      own_lsu_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      resp_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_lsu_q <= last_lsu_d;
      own_lsu_q <= own_lsu_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      resp_q <= resp_d;
      data_q <= data_d;
    end
  end
  assign io_master_arvalid = state_q == AR;
  assign io_master_araddr = addr_q;
  assign io_master_arid = 4'd0;
  assign io_master_arlen = 8'd0;
  assign io_master_arsize = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_rready = state_q == R;
  assign io_master_awvalid = state_q == AW_W && !aw_done_q;
  assign io_master_awaddr = addr_q;
  assign io_master_awid = 4'd0;
  assign io_master_awlen = 8'd0;
  assign io_master_awsize = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid = state_q == AW_W && !w_done_q;
  assign io_master_wdata = wdata_q;
  assign io_master_wstrb = wstrb_q;
  assign io_master_wlast = io_master_wvalid;
  assign io_master_bready = state_q == B;
  assign ifu_rdata_o = data_q;
  assign lsu_rdata_o = data_q;
  assign ifu_rvalid_o = state_q == DONE && !own_lsu_q;
  assign lsu_rvalid_o = state_q == DONE && own_lsu_q && !wr_q;
  assign lsu_wready_o = state_q == DONE && own_lsu_q && wr_q;
  assign err_o = state_q == DONE && resp_q != 2'b00;
endmodule

// File: tb/tb_ysyx_axi_arbiter.sv
// tb_ysyx_axi_arbiter: directed vectors and corner sequences for the AXI arbiter
module tb_ysyx_axi_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] ifu_araddr = 0, lsu_araddr = 0, lsu_awaddr = 0, lsu_wdata = 0;
  logic ifu_arvalid = 0, lsu_arvalid = 0, lsu_wvalid = 0;
  logic [7:0] lsu_rstrb = 0, lsu_wstrb = 0;
  logic [31:0] ifu_rdata_o, lsu_rdata_o;
  logic ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, err_o;
  logic awready = 0, awvalid, wready = 0, wvalid, wlast, bready, bvalid = 0;
  logic arready = 0, arvalid, rready, rvalid = 0, rlast = 0;
  logic [31:0] awaddr, araddr;
  logic [3:0] awid, arid;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp = 0, rresp = 0;
  logic [63:0] wdata, rdata = 0;
  logic [63:0] rdata_cfg = 0;
  logic [1:0] rresp_cfg = 0, bresp_cfg = 0;
  bit r_en = 1;
  int w_delay = 0, b_delay = 0, w_cnt = 0, b_cnt = 0;
  int n_vec = 0, n_bad = 0;
  int order[$];
  int p_lat, overlap, extra;
  logic [31:0] p_data, seen_araddr;
  logic [2:0] seen_arsize;
  bit p_err;

  ysyx_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready_o(lsu_wready_o), .err_o(err_o),
    .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast)
  );

  always #5 clk = ~clk;

  // Slave: AR/AW always ready, W and B after configurable waits, R as soon as rready is seen
  always @(negedge clk) begin
    arready = 1;
    awready = 1;
    w_cnt = wvalid ? w_cnt + 1 : 0;
    wready = wvalid && w_cnt > w_delay;
    b_cnt = bready ? b_cnt + 1 : 0;
    bvalid = bready && b_cnt > b_delay;
    bresp = bresp_cfg;
    rvalid = rready && r_en;
    rlast = rvalid;
    rdata = rdata_cfg;
    rresp = rresp_cfg;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic serve();
    int c = 0;
    order.delete();
    overlap = 0;
    while ((ifu_arvalid || lsu_arvalid || lsu_wvalid) && c < 60) begin
      step();
      c++;
      if (arvalid) begin
        seen_araddr = araddr;
        seen_arsize = arsize;
      end
      if (arvalid && (awvalid || wvalid)) overlap++;
      if (ifu_rvalid_o || lsu_rvalid_o || lsu_wready_o) begin
        p_lat = c;
        p_data = ifu_rvalid_o ? ifu_rdata_o : lsu_rdata_o;
        p_err = err_o;
      end
      if (ifu_rvalid_o) begin order.push_back(0); ifu_arvalid = 0; end
      if (lsu_rvalid_o) begin order.push_back(1); lsu_arvalid = 0; end
      if (lsu_wready_o) begin order.push_back(2); lsu_wvalid = 0; end
    end
    chk("within_budget", c < 60, 1);
    step();
    extra = ifu_rvalid_o + lsu_rvalid_o + lsu_wready_o;
  endtask

  typedef struct {
    bit lsu;
    logic [31:0] addr;
    logic [7:0] strb;
    logic [63:0] rd;
    logic [1:0] resp;
    logic [2:0] size;
    logic [31:0] data;
    bit err;
  } rvec_t;
  rvec_t vec[6];

  initial begin
    vec[0] = '{0, 32'h3000_0004, 8'h0f, 64'hDEADBEEF_12345678, 2'b00, 3'd2, 32'hDEADBEEF, 0};
    vec[1] = '{1, 32'h0F00_0003, 8'h01, 64'h11223344_AABBCCDD, 2'b00, 3'd0, 32'h0000_00AA, 0};
    vec[2] = '{1, 32'h8000_0006, 8'h03, 64'h55667788_99AABBCC, 2'b00, 3'd1, 32'h0000_5566, 0};
    vec[3] = '{1, 32'h8000_0000, 8'h0f, 64'h01020304_CAFEF00D, 2'b10, 3'd2, 32'hCAFE_F00D, 1};
    vec[4] = '{0, 32'h3000_0000, 8'h00, 64'h01020304_0BADC0DE, 2'b00, 3'd2, 32'h0BAD_C0DE, 0};
    vec[5] = '{0, 32'h3000_0008, 8'h00, 64'h00000000_0000ABCD, 2'b11, 3'd2, 32'h0000_ABCD, 1};
    repeat (3) step();
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_pulses", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o, err_o}, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_data", {ifu_rdata_o, wstrb}, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      rdata_cfg = vec[i].rd;
      rresp_cfg = vec[i].resp;
      if (vec[i].lsu) begin
        lsu_araddr = vec[i].addr; lsu_rstrb = vec[i].strb; lsu_arvalid = 1;
      end else begin
        ifu_araddr = vec[i].addr; ifu_arvalid = 1;
      end
      serve();
      chk($sformatf("v%0d_araddr", i), seen_araddr, vec[i].addr);
      chk($sformatf("v%0d_arsize", i), seen_arsize, vec[i].size);
      chk($sformatf("v%0d_latency", i), p_lat, 3);
      chk($sformatf("v%0d_data", i), p_data, vec[i].data);
      chk($sformatf("v%0d_err", i), p_err, vec[i].err);
      chk($sformatf("v%0d_owner", i), {order.size(), 32'(vec[i].lsu)}, {32'd1, 32'(vec[i].lsu)});
      chk($sformatf("v%0d_extra_pulse", i), extra, 0);
    end
    // Store with W accepted two cycles after AW and one B wait cycle
    w_delay = 2; b_delay = 1; bresp_cfg = 0;
    lsu_awaddr = 32'h0F00_0006; lsu_wdata = 32'h0000_BEEF; lsu_wstrb = 8'h03; lsu_wvalid = 1;
    step();
    chk("st_c1_valids", {awvalid, wvalid}, 2'b11);
    chk("st_awaddr", awaddr, 32'h0F00_0006);
    chk("st_awsize_len", {awsize, awlen, awburst}, {3'd1, 8'd0, 2'b01});
    chk("st_wdata", wdata, 64'hBEEF0000_BEEF0000);
    chk("st_wstrb_wlast", {wstrb, wlast}, {8'hC0, 1'b1});
    step();
    chk("st_c2_valids", {awvalid, wvalid}, 2'b01);
    step();
    chk("st_c3_valids", {awvalid, wvalid, lsu_wready_o}, 3'b010);
    step();
    chk("st_c4_b", {awvalid, wvalid, bready, lsu_wready_o}, 4'b0010);
    step();
    chk("st_c5_wait_b", {bready, lsu_wready_o}, 2'b10);
    step();
    chk("st_c6_pulse", {lsu_wready_o, err_o, bready}, 3'b100);
    lsu_wvalid = 0;
    step();
    chk("st_c7_no_pulse", lsu_wready_o, 0);
    // Minimum-latency store with an error response
    w_delay = 0; b_delay = 0; bresp_cfg = 2'b01;
    lsu_awaddr = 32'h8000_0000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 8'h0f; lsu_wvalid = 1;
    serve();
    chk("st2_latency", p_lat, 3);
    chk("st2_err", p_err, 1);
    chk("st2_extra_pulse", extra, 0);
    bresp_cfg = 0;
    // Contended reads: LSU first, then round-robin flips to IFU first
    rdata_cfg = 64'h0;
    rresp_cfg = 0;
    for (int k = 0; k < 2; k++) begin
      ifu_araddr = 32'h3000_0020; ifu_arvalid = 1;
      lsu_araddr = 32'h8000_0010; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
      serve();
      chk($sformatf("rr%0d_count", k), order.size(), 2);
      chk($sformatf("rr%0d_first", k), order[0], k == 0 ? 1 : 0);
      chk($sformatf("rr%0d_second", k), order[1], k == 0 ? 0 : 1);
      chk($sformatf("rr%0d_overlap", k), overlap, 0);
    end
    // Store and load together: store is served first
    lsu_awaddr = 32'h8000_0004; lsu_wdata = 32'hA5A5_A5A5; lsu_wstrb = 8'h0f; lsu_wvalid = 1;
    lsu_araddr = 32'h8000_0004; lsu_arvalid = 1;
    serve();
    chk("sl_count", order.size(), 2);
    chk("sl_order", {order[0], order[1]}, {32'd2, 32'd1});
    chk("sl_overlap", overlap, 0);
    // Reset while waiting in R with rvalid withheld
    r_en = 0;
    ifu_araddr = 32'h3000_0010; ifu_arvalid = 1;
    step();
    chk("rs_ar", arvalid, 1);
    step();
    chk("rs_in_r", rready, 1);
    rst = 1;
    step();
    chk("rs_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rs_pulses", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
    rst = 0; r_en = 1;
    rdata_cfg = 64'hFEEDFACE_00C0FFEE;
    ifu_araddr = 32'h3000_0014;
    serve();
    chk("rs_fresh_latency", p_lat, 3);
    chk("rs_fresh_data", p_data, 32'hFEEDFACE);
    chk("rs_fresh_araddr", seen_araddr, 32'h3000_0014);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
